// File: rtl/dma_ci_sequencer_if.sv
// CI bus bundle for dma_ci_sequencer: CPU-facing custom-instruction port,
// the CI master port towards the DMA block, and the queue-drained irq.
interface dma_ci_sequencer_if;
    logic        start;
    logic [7:0]  ciN;
    logic [31:0] valueA;
    logic [31:0] valueB;
    logic        done;
    logic [31:0] result;
    logic        dmaStart;
    logic [31:0] dmaValueA;
    logic [31:0] dmaValueB;
    logic        dmaDone;
    logic [31:0] dmaResult;
    logic        irq;

    // slave = the sequencer; master = CPU plus DMA block around it
    modport slave (
        input  start, ciN, valueA, valueB, dmaDone, dmaResult,
        output done, result, dmaStart, dmaValueA, dmaValueB, irq
    );
    modport master (
        output start, ciN, valueA, valueB, dmaDone, dmaResult,
        input  done, result, dmaStart, dmaValueA, dmaValueB, irq
    );
endinterface

// File: rtl/dma_ci_sequencer.sv
// Descriptor-queue sequencer: queues CPU-pushed DMA descriptors and programs/polls the
// DMA CI block one descriptor at a time. Optional queue-drained irq under DMA_SEQ_IRQ_EN.
module dma_ci_sequencer #(
    parameter logic [7:0] customId   = 8'h01,
    parameter int         DEPTH_LOG2 = 2,
    parameter int         POLL_GAP   = 4
) (
    input logic               clock,
    input logic               reset,
    dma_ci_sequencer_if.slave bus
);
    localparam int                DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam int                GAP_W     = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;

    typedef struct packed {
        logic [31:0] busAddr;
        logic [8:0]  mem;
        logic [9:0]  size;
        logic [7:0]  burst;
        logic        dirIn;
    } desc_t;

    typedef enum logic [3:0] {
        IDLE, POP, WR_BUS, WR_MEM, WR_SIZE, WR_BURST, KICK, GAP, POLL, RETIRE
    } state_t;

    state_t                state, stateNext;
    desc_t [DEPTH-1:0]     fifoMem;
    logic [DEPTH_LOG2-1:0] wrPtr, rdPtr;
    logic [DEPTH_LOG2:0]   count;
    desc_t                 cur, pushDesc;
    logic [31:0]           stagedAddr, ciResult, accA, accB;
    logic [15:0]           doneCnt;
    logic [7:0]            errCnt;
    logic [GAP_W-1:0]      gapCnt;
    logic [2:0]            op;
    logic stickyErr, lastErr, issued, isAccess, launch, advance;
    logic accept, pushOk, pop, clear, full, fsmBusy;
    logic unusedBits;

    assign unusedBits = ^{bus.valueA[31:3], bus.valueB[31:28], bus.dmaResult[31:2]};

    assign accept   = bus.start && (bus.ciN == customId);
    assign op       = bus.valueA[2:0];
    assign full     = (count == DEPTH_CNT);
    assign fsmBusy  = (state != IDLE);
    assign pushDesc = {stagedAddr, bus.valueB[8:0], bus.valueB[18:9], bus.valueB[26:19], bus.valueB[27]};
    assign pushOk   = accept && (op == 3'd2) && !full && (pushDesc.size != '0);
    assign clear    = accept && (op == 3'd4);
    assign pop      = (state == IDLE) && (count != '0);

    always_comb begin
        ciResult = '0;
        case (op)
            3'd1:    ciResult = 32'd1;
            3'd2:    ciResult = {31'd0, pushOk};
            3'd3:    ciResult = {errCnt, doneCnt, 5'(count), stickyErr, fsmBusy, full};
            3'd4:    ciResult = 32'd1;
            default: ciResult = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bus.done   <= 1'b0;
            bus.result <= '0;
            stagedAddr <= '0;
        end else begin
            bus.done   <= accept;
            bus.result <= accept ? ciResult : '0;
            if (accept && op == 3'd1) stagedAddr <= bus.valueB;
        end
    end

    // Full-check uses the pre-pop count, so a same-cycle pop never frees a slot early
    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            cur   <= '0;
        end else begin
            if (pushOk) wrPtr <= wrPtr + 1'b1;
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
                cur   <= fifoMem[rdPtr];
            end
            count <= count + (DEPTH_LOG2 + 1)'(pushOk) - (DEPTH_LOG2 + 1)'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (pushOk) fifoMem[wrPtr] <= pushDesc;
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    // issued is high from the dmaStart cycle on, so same-cycle dmaDone is honoured
    assign advance = issued && bus.dmaDone;

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:     if (count != '0) stateNext = POP;
            POP:      if (advance) stateNext = WR_BUS;
            WR_BUS:   if (advance) stateNext = WR_MEM;
            WR_MEM:   if (advance) stateNext = WR_SIZE;
            WR_SIZE:  if (advance) stateNext = WR_BURST;
            WR_BURST: if (advance) stateNext = KICK;
            KICK:     stateNext = GAP;
            GAP:      if (gapCnt == GAP_W'(POLL_GAP)) stateNext = POLL;
            POLL:     if (advance) stateNext = bus.dmaResult[0] ? GAP : RETIRE;
            RETIRE:   stateNext = IDLE;
            default:  stateNext = IDLE;
        endcase
    end

    always_comb begin
        isAccess = 1'b1;
        accA     = '0;
        accB     = '0;
        case (state)
            POP:      begin accA = 32'h600;  accB = cur.busAddr; end
            WR_BUS:   begin accA = 32'hA00;  accB = {23'd0, cur.mem}; end
            WR_MEM:   begin accA = 32'hE00;  accB = {22'd0, cur.size}; end
            WR_SIZE:  begin accA = 32'h1200; accB = {24'd0, cur.burst}; end
            WR_BURST: begin accA = 32'h1600; accB = cur.dirIn ? 32'd1 : 32'd2; end
            POLL:     begin accA = 32'h1400; accB = '0; end
            default:  isAccess = 1'b0;
        endcase
    end

    assign launch = isAccess && !issued;

    always_ff @(posedge clock) begin
        if (reset) begin
            bus.dmaStart  <= 1'b0;
            bus.dmaValueA <= '0;
            bus.dmaValueB <= '0;
            issued        <= 1'b0;
            gapCnt        <= '0;
            lastErr       <= 1'b0;
        end else begin
            bus.dmaStart <= launch;
            if (launch) begin
                bus.dmaValueA <= accA;
                bus.dmaValueB <= accB;
            end else if (state == IDLE) begin
                bus.dmaValueA <= '0;
                bus.dmaValueB <= '0;
            end
            if (stateNext != state) issued <= 1'b0;
            else if (launch)        issued <= 1'b1;
            gapCnt <= (state == GAP) ? gapCnt + 1'b1 : '0;
            if (state == POLL && advance) lastErr <= bus.dmaResult[1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            doneCnt   <= '0;
            errCnt    <= '0;
            stickyErr <= 1'b0;
        end else if (state == RETIRE) begin
            doneCnt <= doneCnt + 1'b1;
            if (lastErr) begin
                if (errCnt != 8'hFF) errCnt <= errCnt + 1'b1;
                stickyErr <= 1'b1;
            end
        end
    end

`ifdef DMA_SEQ_IRQ_EN
    always_ff @(posedge clock) begin
        if (reset || clear)                     bus.irq <= 1'b0;
        else if (state == RETIRE && count == '0) bus.irq <= 1'b1;
    end
`else
    assign bus.irq = 1'b0;
`endif
endmodule

// File: tb/tb_dma_ci_sequencer.sv
// Directed bench for dma_ci_sequencer with a small model DMA block on the master port.
`timescale 1ns/1ps
module tb_dma_ci_sequencer;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

`ifdef DMA_SEQ_IRQ_EN
    localparam logic IRQ_EN = 1'b1;
`else
    localparam logic IRQ_EN = 1'b0;
`endif

    dma_ci_sequencer_if bus();

    dma_ci_sequencer #(.customId(8'h01), .DEPTH_LOG2(2), .POLL_GAP(4)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model DMA: config writes complete same cycle, status reads one cycle later
    logic        dmaBusy = 1'b0, dmaErr = 1'b0;
    logic        pollPend = 1'b0, prevStart = 1'b0;
    logic [31:0] pollRes = '0;
    logic [63:0] accLog [0:1023];
    int          logN = 0, pollN = 0, protoErr = 0;

    assign bus.dmaDone   = (bus.dmaStart && bus.dmaValueA != 32'h1400) || pollPend;
    assign bus.dmaResult = pollPend ? pollRes : 32'h0;

    always @(posedge clock) begin
        pollPend  <= bus.dmaStart && (bus.dmaValueA == 32'h1400);
        prevStart <= bus.dmaStart;
        if (bus.dmaStart) begin
            if (pollPend || prevStart) protoErr <= protoErr + 1;
            if (bus.dmaValueA == 32'h1400) begin
                pollN   <= pollN + 1;
                pollRes <= dmaBusy ? 32'h1 : (dmaErr ? 32'h2 : 32'h0);
            end else begin
                if (logN < 1024) accLog[logN] <= {bus.dmaValueA, bus.dmaValueB};
                logN <= logN + 1;
            end
        end
    end

    task automatic ci(input logic [2:0] op, input logic [31:0] b,
                      output logic [31:0] res, output logic dn);
        @(negedge clock);
        bus.start = 1'b1; bus.ciN = 8'h01; bus.valueA = {29'd0, op}; bus.valueB = b;
        @(negedge clock);
        bus.start = 1'b0; bus.valueA = '0; bus.valueB = '0;
        res = bus.result; dn = bus.done;
    endtask

    task automatic wait_idle(output logic [31:0] st, output logic ok);
        logic d;
        ok = 1'b0;
        st = '0;
        for (int i = 0; i < 300 && !ok; i++) begin
            ci(3'd3, 32'd0, st, d);
            if (st[1] == 1'b0 && st[7:3] == 5'd0) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        logic [31:0] r; logic d;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        checks++;
        if (bus.done !== 1'b0 || bus.result !== 32'h0 || bus.dmaStart !== 1'b0 || bus.irq !== 1'b0 ||
            bus.dmaValueA !== 32'h0 || bus.dmaValueB !== 32'h0) begin
            errors++; $display("FAIL reset_outputs: done=%b result=%h dmaStart=%b irq=%b A=%h B=%h, want all 0",
                               bus.done, bus.result, bus.dmaStart, bus.irq, bus.dmaValueA, bus.dmaValueB);
        end
        ci(3'd3, 32'd0, r, d);
        checks++;
        if (d !== 1'b1 || r !== 32'h0) begin
            errors++; $display("FAIL reset_status: done=%b result=%h, want 1 / 00000000", d, r);
        end
        @(negedge clock);
        checks++;
        if (bus.done !== 1'b0 || bus.result !== 32'h0) begin
            errors++; $display("FAIL done_pulse: done=%b result=%h, want 0 / 0", bus.done, bus.result);
        end
        // foreign ciN must be ignored
        bus.start = 1'b1; bus.ciN = 8'h02; bus.valueA = 32'd1; bus.valueB = 32'd0;
        @(negedge clock);
        bus.start = 1'b0; bus.ciN = 8'h01; bus.valueA = '0;
        checks++;
        if (bus.done !== 1'b0) begin
            errors++; $display("FAIL foreign_ciN: done=%b, want 0", bus.done);
        end
        checks++;
        if (logN !== 0 || pollN !== 0 || bus.dmaStart !== 1'b0) begin
            errors++; $display("FAIL reset_no_dma: accesses=%0d polls=%0d, want 0 0", logN, pollN);
        end
        ci(3'd0, 32'd0, r, d);
        checks++;
        if (d !== 1'b1 || r !== 32'h0) begin
            errors++; $display("FAIL op0: done=%b result=%h, want 1 / 0", d, r);
        end
    endtask

    task automatic test_single;
        logic [31:0] r, a2, b2, st; logic d, ok, s0, s1, s2;
        logic [63:0] exp [5];
        int base;
        base = logN;
        dmaBusy = 1'b1;
        ci(3'd1, 32'h1000_0000, r, d);
        checks++;
        if (d !== 1'b1 || r !== 32'h1) begin
            errors++; $display("FAIL stage_addr: done=%b result=%h, want 1 / 1", d, r);
        end
        @(negedge clock);
        bus.start = 1'b1; bus.valueA = 32'd2; bus.valueB = 32'h0878_8000;
        @(negedge clock);
        bus.start = 1'b0; bus.valueA = '0; bus.valueB = '0;
        r = bus.result; d = bus.done; s0 = bus.dmaStart;
        @(negedge clock); s1 = bus.dmaStart;
        @(negedge clock); s2 = bus.dmaStart; a2 = bus.dmaValueA; b2 = bus.dmaValueB;
        checks++;
        if (d !== 1'b1 || r !== 32'h1) begin
            errors++; $display("FAIL push_single: done=%b result=%h, want 1 / 1", d, r);
        end
        checks++;
        if ({s0, s1, s2} !== 3'b001 || a2 !== 32'h600 || b2 !== 32'h1000_0000) begin
            errors++; $display("FAIL first_start_latency: starts=%b A=%h B=%h, want 001 600 10000000", {s0, s1, s2}, a2, b2);
        end
        repeat (40) @(negedge clock);
        ci(3'd3, 32'd0, r, d);
        checks++;
        if (r !== 32'h2 || pollN == 0) begin
            errors++; $display("FAIL polling_busy: status=%h polls=%0d, want 00000002 and polls>0", r, pollN);
        end
        dmaBusy = 1'b0;
        wait_idle(st, ok);
        checks++;
        if (!ok || st !== 32'h100) begin
            errors++; $display("FAIL single_done: idle=%b status=%h, want 1 / 00000100", ok, st);
        end
        exp[0] = {32'h600, 32'h1000_0000}; exp[1] = {32'hA00, 32'h0};
        exp[2] = {32'hE00, 32'd64};       exp[3] = {32'h1200, 32'd15};
        exp[4] = {32'h1600, 32'd1};
        checks++;
        if (logN - base !== 5) begin
            errors++; $display("FAIL single_access_count: got %0d want 5", logN - base);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (accLog[base + i] !== exp[i]) begin
                errors++; $display("FAIL single_access%0d: got %h want %h", i, accLog[base + i], exp[i]);
            end
        end
        checks++;
        if (bus.irq !== IRQ_EN) begin
            errors++; $display("FAIL irq_after_drain: got %b want %b", bus.irq, IRQ_EN);
        end
        ci(3'd4, 32'd0, r, d);
        ci(3'd3, 32'd0, st, d);
        checks++;
        if (r !== 32'h1 || st !== 32'h0 || bus.irq !== 1'b0) begin
            errors++; $display("FAIL clear_single: clear=%h status=%h irq=%b, want 1 0 0", r, st, bus.irq);
        end
    endtask

    task automatic test_fifo_full;
        logic [31:0] r, st; logic d, ok;
        logic [63:0] exp [25];
        int base;
        base = logN;
        dmaBusy = 1'b1;
        ci(3'd1, 32'h2000_0000, r, d);
        ci(3'd2, 32'h0000_2000, r, d);
        checks++;
        if (r !== 32'h1) begin
            errors++; $display("FAIL push_inflight: got %h want 1", r);
        end
        repeat (40) @(negedge clock);
        for (int k = 1; k <= 5; k++) begin
            ci(3'd1, 32'h2000_0000 + k, r, d);
            ci(3'd2, 32'h0000_2000 | k, r, d);
            checks++;
            if (r !== ((k <= 4) ? 32'h1 : 32'h0)) begin
                errors++; $display("FAIL push_full%0d: got %h want %h", k, r, (k <= 4) ? 32'h1 : 32'h0);
            end
        end
        ci(3'd3, 32'd0, r, d);
        checks++;
        if (r !== 32'h23) begin
            errors++; $display("FAIL full_status: got %h want 00000023", r);
        end
        dmaBusy = 1'b0;
        wait_idle(st, ok);
        checks++;
        if (!ok || st !== 32'h500) begin
            errors++; $display("FAIL fifo_drain: idle=%b status=%h, want 1 / 00000500", ok, st);
        end
        for (int k = 0; k < 5; k++) begin
            exp[k*5 + 0] = {32'h600, 32'h2000_0000 + k};
            exp[k*5 + 1] = {32'hA00, 32'(k)};
            exp[k*5 + 2] = {32'hE00, 32'd16};
            exp[k*5 + 3] = {32'h1200, 32'd0};
            exp[k*5 + 4] = {32'h1600, 32'd2};
        end
        checks++;
        if (logN - base !== 25) begin
            errors++; $display("FAIL fifo_access_count: got %0d want 25", logN - base);
        end
        for (int i = 0; i < 25; i++) begin
            checks++;
            if (accLog[base + i] !== exp[i]) begin
                errors++; $display("FAIL fifo_order%0d: got %h want %h", i, accLog[base + i], exp[i]);
            end
        end
    endtask

    task automatic test_size_zero;
        logic [31:0] r; logic d;
        int base, pb;
        base = logN; pb = pollN;
        ci(3'd2, 32'h0008_0003, r, d);
        checks++;
        if (d !== 1'b1 || r !== 32'h0) begin
            errors++; $display("FAIL push_size0: done=%b result=%h, want 1 / 0", d, r);
        end
        repeat (20) @(negedge clock);
        checks++;
        if (logN !== base || pollN !== pb) begin
            errors++; $display("FAIL size0_no_dma: accesses=%0d polls=%0d, want %0d %0d", logN, pollN, base, pb);
        end
        ci(3'd3, 32'd0, r, d);
        checks++;
        if (r !== 32'h500) begin
            errors++; $display("FAIL size0_status: got %h want 00000500", r);
        end
    endtask

    task automatic test_error;
        logic [31:0] r, st; logic d, ok;
        ci(3'd4, 32'd0, r, d);
        ci(3'd3, 32'd0, st, d);
        checks++;
        if (r !== 32'h1 || st !== 32'h0 || bus.irq !== 1'b0) begin
            errors++; $display("FAIL clear_pre_err: clear=%h status=%h irq=%b, want 1 0 0", r, st, bus.irq);
        end
        dmaErr = 1'b1; dmaBusy = 1'b0;
        ci(3'd1, 32'h4000_0000, r, d);
        ci(3'd2, 32'h0000_0200, r, d);
        checks++;
        if (r !== 32'h1) begin
            errors++; $display("FAIL push_err: got %h want 1", r);
        end
        wait_idle(st, ok);
        checks++;
        if (!ok || st !== 32'h0100_0104) begin
            errors++; $display("FAIL err_status: idle=%b status=%h, want 1 / 01000104", ok, st);
        end
        checks++;
        if (bus.irq !== IRQ_EN) begin
            errors++; $display("FAIL irq_after_err: got %b want %b", bus.irq, IRQ_EN);
        end
        dmaErr = 1'b0;
        ci(3'd4, 32'd0, r, d);
        ci(3'd3, 32'd0, st, d);
        checks++;
        if (st[31:24] !== 8'h0 || st[2] !== 1'b0 || st !== 32'h0 || bus.irq !== 1'b0) begin
            errors++; $display("FAIL clear_err: status=%h irq=%b, want 00000000 0", st, bus.irq);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] r; logic d, hit;
        int base, pb;
        ci(3'd1, 32'h3000_0000, r, d);
        ci(3'd2, 32'h0000_2007, r, d);
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clock);
            if (bus.dmaStart && bus.dmaValueA == 32'h1200) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++; $display("FAIL reach_wr_size: got no 1200 access, want one within 100 cycles");
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (bus.dmaStart !== 1'b0 || bus.dmaValueA !== 32'h0 || bus.dmaValueB !== 32'h0) begin
            errors++; $display("FAIL reset_mid_outputs: start=%b A=%h B=%h, want 0 0 0", bus.dmaStart, bus.dmaValueA, bus.dmaValueB);
        end
        reset = 1'b0;
        base = logN; pb = pollN;
        ci(3'd3, 32'd0, r, d);
        checks++;
        if (r !== 32'h0) begin
            errors++; $display("FAIL reset_mid_status: got %h want 00000000", r);
        end
        repeat (20) @(negedge clock);
        checks++;
        if (logN !== base || pollN !== pb || bus.irq !== 1'b0) begin
            errors++; $display("FAIL reset_mid_quiet: accesses=%0d polls=%0d irq=%b, want %0d %0d 0", logN, pollN, bus.irq, base, pb);
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.ciN = 8'h0; bus.valueA = '0; bus.valueB = '0;
        test_reset();
        test_single();
        test_fifo_full();
        test_size_zero();
        test_error();
        test_reset_mid();
        checks++;
        if (protoErr !== 0) begin
            errors++; $display("FAIL master_protocol: got %0d early restarts want 0", protoErr);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
